// File: rtl/wb_pkg.sv
// Shared widths and types for the writeback register file and its pending-write scoreboard.
package wb_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 2**ADDR_W;
  localparam int CNT_W  = 2;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam cnt_t CNT_MAX = cnt_t'((1 << CNT_W) - 1);
endpackage

// File: rtl/wb_pending_cnt.sv
// Saturating up/down count of in-flight writes for one register; updates on clk, no backpressure.
// over/under flag a saturating inc/dec in the current cycle; the count holds instead of wrapping.
module wb_pending_cnt
  import wb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output cnt_t count,
  output logic over,
  output logic under
);

  assign over  = inc && !dec && (count == CNT_MAX);
  assign under = dec && !inc && (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && !over) begin
      count <= count + cnt_t'(1);
    end else if (dec && !inc && !under) begin
      count <= count - cnt_t'(1);
    end
  end

endmodule

// File: rtl/wb_reg_file.sv
// 8x16 register file with write-through read bypass and per-register pending-write scoreboard.
// Reads/busy are combinational; stall is advisory only. Macro WB_REG_FILE_R0_ZERO_EN hardwires r0 to zero.
module wb_reg_file
  import wb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      wr_en,
  input  reg_addr_t write_addr,
  input  data_t     write_data,
  input  reg_addr_t rd_addr_a,
  input  reg_addr_t rd_addr_b,
  output data_t     rd_data_a,
  output data_t     rd_data_b,
  input  logic      issue_en,
  input  reg_addr_t issue_addr,
  output logic      busy_a,
  output logic      busy_b,
  output logic      stall,
  output logic      sb_err
);

`ifdef WB_REG_FILE_R0_ZERO_EN
  localparam logic R0_ZERO = 1'b1;
`else
  localparam logic R0_ZERO = 1'b0;
`endif

  data_t             regs [NREGS];
  cnt_t              cnt  [NREGS];
  logic [NREGS-1:0]  inc_v;
  logic [NREGS-1:0]  dec_v;
  logic [NREGS-1:0]  over_v;
  logic [NREGS-1:0]  under_v;
  logic              wr_ok;
  logic              a_zero;
  logic              b_zero;
  logic              a_hit;
  logic              b_hit;

  assign wr_ok = wr_en && !(R0_ZERO && (write_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[write_addr] <= write_data;
    end
  end

  // r0 reads as zero ahead of the bypass when the hardwired-zero build is selected.
  assign a_zero = R0_ZERO && (rd_addr_a == '0);
  assign b_zero = R0_ZERO && (rd_addr_b == '0);
  assign a_hit  = wr_en && (write_addr == rd_addr_a);
  assign b_hit  = wr_en && (write_addr == rd_addr_b);

  assign rd_data_a = a_zero ? '0 : (a_hit ? write_data : regs[rd_addr_a]);
  assign rd_data_b = b_zero ? '0 : (b_hit ? write_data : regs[rd_addr_b]);

  for (genvar i = 0; i < NREGS; i++) begin : g_cnt
    localparam logic SKIP = R0_ZERO && (i == 0);

    assign inc_v[i] = !SKIP && issue_en && (issue_addr == reg_addr_t'(i));
    assign dec_v[i] = !SKIP && wr_en    && (write_addr == reg_addr_t'(i));

    wb_pending_cnt u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_v[i]),
      .dec   (dec_v[i]),
      .count (cnt[i]),
      .over  (over_v[i]),
      .under (under_v[i])
    );
  end

  // The last outstanding write retiring this cycle is covered by the bypass, so it does not stall.
  assign busy_a = !a_zero && (cnt[rd_addr_a] != '0) && !((cnt[rd_addr_a] == cnt_t'(1)) && a_hit);
  assign busy_b = !b_zero && (cnt[rd_addr_b] != '0) && !((cnt[rd_addr_b] == cnt_t'(1)) && b_hit);
  assign stall  = busy_a || busy_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_err <= 1'b0;
    end else if ((|over_v) || (|under_v)) begin
      sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed-vector bench for wb_reg_file; expectations are hand-computed per step.
module tb_wb_reg_file;
  import wb_pkg::*;

  logic      clk;
  logic      rst;
  logic      wr_en;
  reg_addr_t write_addr;
  data_t     write_data;
  reg_addr_t rd_addr_a;
  reg_addr_t rd_addr_b;
  data_t     rd_data_a;
  data_t     rd_data_b;
  logic      issue_en;
  reg_addr_t issue_addr;
  logic      busy_a;
  logic      busy_b;
  logic      stall;
  logic      sb_err;

  int n_vec = 0;
  int n_mis = 0;

`ifdef WB_REG_FILE_R0_ZERO_EN
  localparam logic R0_ZERO = 1'b1;
`else
  localparam logic R0_ZERO = 1'b0;
`endif

  wb_reg_file dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .busy_a     (busy_a),
    .busy_b     (busy_b),
    .stall      (stall),
    .sb_err     (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks run 1 unit after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    issue_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    write_addr = '0;
    write_data = '0;
    issue_addr = '0;
    rd_addr_a  = '0;
    rd_addr_b  = '0;
    #2;
    for (int i = 0; i < NREGS; i++) begin
      rd_addr_a = reg_addr_t'(i);
      rd_addr_b = reg_addr_t'(NREGS - 1 - i);
      #1;
      chk($sformatf("rst_rd_a%0d", i), rd_data_a, 16'h0000);
      chk($sformatf("rst_rd_b%0d", i), rd_data_b, 16'h0000);
    end
    chk("rst_stall", {15'd0, stall}, 16'd0);
    chk("rst_sb_err", {15'd0, sb_err}, 16'd0);
    tick();
    rst = 1'b0;
    tick();

    // issue r5, then write 0x1234 with bypass on port b
    issue_en = 1'b1; issue_addr = 3'd5;
    tick();
    idle();
    rd_addr_a = 3'd0; rd_addr_b = 3'd5;
    #1;
    chk("r5_busy_b_pre", {15'd0, busy_b}, 16'd1);
    wr_en = 1'b1; write_addr = 3'd5; write_data = 16'h1234;
    #1;
    chk("r5_bypass_b", rd_data_b, 16'h1234);
    chk("r5_bypass_a_other", rd_data_a, 16'h0000);
    chk("r5_busy_b_wb", {15'd0, busy_b}, 16'd0);
    tick();
    idle();
    rd_addr_a = 3'd5;
    #1;
    chk("r5_rd_a", rd_data_a, 16'h1234);
    chk("r5_same_port", rd_data_b, 16'h1234);

    // issue r3, two idle cycles, then retire with bypass
    issue_en = 1'b1; issue_addr = 3'd3;
    tick();
    idle();
    tick();
    tick();
    rd_addr_a = 3'd3;
    #1;
    chk("r3_busy_a", {15'd0, busy_a}, 16'd1);
    chk("r3_stall", {15'd0, stall}, 16'd1);
    wr_en = 1'b1; write_addr = 3'd3; write_data = 16'h00FF;
    #1;
    chk("r3_busy_a_wb", {15'd0, busy_a}, 16'd0);
    chk("r3_bypass_a", rd_data_a, 16'h00FF);
    chk("r3_stall_wb", {15'd0, stall}, 16'd0);
    tick();
    idle();
    #1;
    chk("r3_busy_after", {15'd0, busy_a}, 16'd0);
    chk("r3_rd_after", rd_data_a, 16'h00FF);

    // WAW on r2
    issue_en = 1'b1; issue_addr = 3'd2;
    tick();
    tick();
    idle();
    rd_addr_a = 3'd2;
    #1;
    chk("r2_busy_cnt2", {15'd0, busy_a}, 16'd1);
    wr_en = 1'b1; write_addr = 3'd2; write_data = 16'hAAAA;
    #1;
    chk("r2_busy_wb_cnt2", {15'd0, busy_a}, 16'd1);
    tick();
    idle();
    #1;
    chk("r2_busy_cnt1", {15'd0, busy_a}, 16'd1);
    issue_en = 1'b1; issue_addr = 3'd2;
    wr_en = 1'b1; write_addr = 3'd2; write_data = 16'hBBBB;
    #1;
    chk("r2_busy_iss_wb", {15'd0, busy_a}, 16'd0);
    tick();
    idle();
    #1;
    chk("r2_busy_held", {15'd0, busy_a}, 16'd1);
    chk("r2_rd_bbbb", rd_data_a, 16'hBBBB);
    wr_en = 1'b1; write_addr = 3'd2; write_data = 16'hCCCC;
    tick();
    idle();
    #1;
    chk("r2_busy_done", {15'd0, busy_a}, 16'd0);
    chk("r2_sb_err", {15'd0, sb_err}, 16'd0);

    // overflow on r6
    rd_addr_a = 3'd6;
    issue_en = 1'b1; issue_addr = 3'd6;
    tick();
    tick();
    tick();
    chk("r6_sb_err_3", {15'd0, sb_err}, 16'd0);
    tick();
    idle();
    #1;
    chk("r6_sb_err_4", {15'd0, sb_err}, 16'd1);
    wr_en = 1'b1; write_addr = 3'd6; write_data = 16'h0606;
    tick();
    tick();
    idle();
    #1;
    chk("r6_busy_cnt1", {15'd0, busy_a}, 16'd1);
    chk("r6_sb_err_hold", {15'd0, sb_err}, 16'd1);

    // asynchronous reset mid-cycle
    rd_addr_b = 3'd5;
    rst = 1'b1;
    #1;
    chk("arst_busy_a", {15'd0, busy_a}, 16'd0);
    chk("arst_sb_err", {15'd0, sb_err}, 16'd0);
    chk("arst_rd_b", rd_data_b, 16'h0000);
    chk("arst_stall", {15'd0, stall}, 16'd0);
    tick();
    rst = 1'b0;
    tick();

    // r0 behaviour
    rd_addr_a = 3'd0; rd_addr_b = 3'd1;
    issue_en = 1'b1; issue_addr = 3'd0;
    tick();
    idle();
    #1;
    chk("r0_busy_issue", {15'd0, busy_a}, R0_ZERO ? 16'd0 : 16'd1);
    wr_en = 1'b1; write_addr = 3'd0; write_data = 16'hBEEF;
    #1;
    chk("r0_bypass", rd_data_a, R0_ZERO ? 16'h0000 : 16'hBEEF);
    tick();
    idle();
    #1;
    chk("r0_rd", rd_data_a, R0_ZERO ? 16'h0000 : 16'hBEEF);
    chk("r0_busy", {15'd0, busy_a}, 16'd0);
    chk("r0_sb_err", {15'd0, sb_err}, 16'd0);

    // underflow on r7: write still lands, sb_err sets
    wr_en = 1'b1; write_addr = 3'd7; write_data = 16'h7777;
    tick();
    idle();
    rd_addr_b = 3'd7;
    #1;
    chk("r7_rd", rd_data_b, 16'h7777);
    chk("r7_sb_err", {15'd0, sb_err}, 16'd1);
    chk("r7_busy", {15'd0, busy_b}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
